pipeline_redirect_ctrl: RTL
===========================

Name: pipeline_redirect_ctrl

Overview:
Sequences the 5-stage pipeline's program-counter redirects and pipeline-register control. Consumes the EX-stage PC-source selection from the branch-condition generator, the hazard unit's load-use stall request and the external interrupt line. Drives the PC mux select, PC/IF-ID write enables and IF-ID/ID-EX flushes. Owns interrupt entry (drain, take, in-ISR masking until mret) so the branch-condition generator no longer forces the interrupt select itself.

Parameters:
DRAIN_CYCLES, 2, bubble cycles injected before interrupt entry so older EX/MEM instructions retire (legal 1..15)
SYNC_STAGES, 2, flip-flops in the INTR synchronizer (legal 2..3)
CNT_W, 16, width of the saturating redirect counter

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
EX_PC_SOURCE  in  4  PC select computed for the EX instruction: 0 seq, 1 jalr, 2 branch, 3 jal, 5 mret
EX_VALID  in  1  EX holds a real (non-bubble) instruction
LOAD_USE  in  1  hazard unit requests a one-cycle load-use stall
INTR  in  1  asynchronous external interrupt level
MIE  in  1  CSR global interrupt enable
PC_SEL  out  4  PC mux select (4 = interrupt vector)
PC_WRITE  out  1  PC register enable
IF_ID_WRITE  out  1  IF/ID register enable
IF_ID_FLUSH  out  1  IF/ID register clears to bubble
ID_EX_FLUSH  out  1  ID/EX register clears to bubble
INT_TAKEN  out  1  one-cycle pulse: CSR saves mepc and clears MIE
IN_ISR  out  1  handler active
REDIRECT_CNT  out  CNT_W  count of taken redirects, saturating

Behaviour:
- Reset (RST_N low, async): state IDLE, synchronizer and pending cleared, drain counter 0, REDIRECT_CNT 0. Outputs during reset: PC_SEL 0, PC_WRITE 1, IF_ID_WRITE 1, both flushes 0, INT_TAKEN 0, IN_ISR 0. Reset asserted mid-drain or mid-ISR abandons the sequence with no INT_TAKEN.
- INTR passes through SYNC_STAGES flops. pend sets on synced INTR & MIE & ~IN_ISR. pend clears only on INT_TAKEN.
- redirect = EX_VALID & (EX_PC_SOURCE != 0). All outputs are combinational from state plus inputs; the redirect responds in the same cycle.
- State IDLE:
  - redirect: PC_SEL = EX_PC_SOURCE, PC_WRITE 1, IF_ID_FLUSH 1, ID_EX_FLUSH 1, REDIRECT_CNT += 1 (saturates at all-ones). Redirect wins over LOAD_USE the same cycle.
  - else LOAD_USE: PC_WRITE 0, IF_ID_WRITE 0, ID_EX_FLUSH 1, PC_SEL 0.
  - else defaults: PC_SEL 0, enables 1, flushes 0.
  - pend & ~redirect: go to DRAIN, counter loaded with DRAIN_CYCLES. pend in a redirect cycle defers one cycle so the redirect completes first.
- State DRAIN:
  - PC_WRITE 0, IF_ID_WRITE 0, ID_EX_FLUSH 1; LOAD_USE is ignored.
  - Counter decrements each cycle; at 1, go to TAKE.
  - A redirect arriving in DRAIN (older branch resolving) is honoured exactly as in IDLE (PC_SEL, both flushes, PC_WRITE 1, count) and the drain counter reloads.
- State TAKE, one cycle: PC_SEL 4, PC_WRITE 1, IF_ID_FLUSH 1, ID_EX_FLUSH 1, INT_TAKEN 1; next state ISR.
- State ISR:
  - IN_ISR 1; behaves as IDLE for redirects and stalls; new interrupts are not latched.
  - redirect with EX_PC_SOURCE == 5 (mret): perform the redirect, then go to IDLE next cycle.
  - An mret (source 5) seen in IDLE is still redirected, with no state change.
- Unlisted EX_PC_SOURCE values (4, 6..15) are treated as no redirect.

Test Plan:
- Reset release, EX_VALID 0 for 5 cycles -> PC_SEL 0, PC_WRITE 1, all flushes 0, REDIRECT_CNT 0.
- Taken branch (EX_VALID 1, EX_PC_SOURCE 2) with LOAD_USE 1 in the same cycle -> PC_SEL 2, PC_WRITE 1, IF_ID_FLUSH 1, ID_EX_FLUSH 1, REDIRECT_CNT 1; next cycle with no branch -> defaults.
- LOAD_USE 1 alone for one cycle -> PC_WRITE 0, IF_ID_WRITE 0, ID_EX_FLUSH 1, IF_ID_FLUSH 0.
- MIE 1, INTR rises at cycle t, DRAIN_CYCLES 2 -> DRAIN during t+3..t+4, INT_TAKEN and PC_SEL 4 at t+5, IN_ISR 1 from t+6. INTR toggled again in ISR -> no second INT_TAKEN. EX_PC_SOURCE 5 -> PC_SEL 5, IN_ISR 0 next cycle.
- Interrupt pending while a jal (source 3) is in EX -> jal redirect first, DRAIN starts the following cycle. Jalr (source 1) arriving in DRAIN -> PC_SEL 1 honoured, drain restarts at 2 cycles.
- RST_N pulsed low mid-DRAIN -> immediate default outputs, no INT_TAKEN. 2^CNT_W+3 redirects -> REDIRECT_CNT holds at all-ones.

Source files
------------

// File: rtl/pipeline_redirect_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_redirect_ctrl_if : EX/hazard/interrupt inputs and PC/pipe controls
// Revision: 1.0
// ----------------------------------------------------------------------------
interface pipeline_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ex_pc_source;
  logic             ex_valid;
  logic             load_use;
  logic             intr;
  logic             mie;
  logic [3:0]       pc_sel;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             int_taken;
  logic             in_isr;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output ex_pc_source, ex_valid, load_use, intr, mie,
    input  pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush,
           int_taken, in_isr, redirect_cnt
  );

  modport slave (
    input  ex_pc_source, ex_valid, load_use, intr, mie,
    output pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush,
           int_taken, in_isr, redirect_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_redirect_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_redirect_ctrl : PC redirect, stall/flush and interrupt-entry control
// Revision: 1.0
// ----------------------------------------------------------------------------
module pipeline_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipeline_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAKE  = 2'd2,
    ISR   = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [3:0] SEL_INTR   = 4'd4;
  localparam logic [3:0] SEL_MRET   = 4'd5;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   pend;
  logic [3:0]             drain_cnt;
  logic [CNT_W-1:0]       cnt;

  logic src_legal;
  logic redirect;
  logic redirect_taken;
  logic pend_set;
  logic pend_now;

  assign src_legal      = bus.ex_pc_source inside {4'd1, 4'd2, 4'd3, SEL_MRET};
  assign redirect       = bus.ex_valid & src_legal;
  assign redirect_taken = redirect & (state != TAKE);
  assign pend_set       = sync[SYNC_STAGES-1] & bus.mie & (state != ISR);
  // Combine the latched request with this cycle's set so entry is not delayed a cycle.
  assign pend_now       = pend | pend_set;

  assign bus.redirect_cnt = cnt;

  always_comb begin
    bus.pc_sel      = 4'd0;
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.int_taken   = 1'b0;
    bus.in_isr      = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE, ISR: begin
          bus.in_isr = (state == ISR);
          if (redirect) begin
            bus.pc_sel      = bus.ex_pc_source;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
          end else if (bus.load_use) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
          end
        end
        DRAIN: begin
          if (redirect) begin
            bus.pc_sel      = bus.ex_pc_source;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
          end else begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
          end
        end
        TAKE: begin
          bus.pc_sel      = SEL_INTR;
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          bus.int_taken   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync      <= '0;
      pend      <= 1'b0;
      drain_cnt <= 4'd0;
      cnt       <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.intr};

      if (state == TAKE)
        pend <= 1'b0;
      else if (pend_set)
        pend <= 1'b1;

      if (redirect_taken && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (pend_now && !redirect) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          // An older branch resolving mid-drain restarts the bubble count.
          if (redirect)
            drain_cnt <= DRAIN_LOAD;
          else if (drain_cnt == 4'd1)
            state <= TAKE;
          else
            drain_cnt <= drain_cnt - 4'd1;
        end
        TAKE: state <= ISR;
        ISR: begin
          if (redirect && (bus.ex_pc_source == SEL_MRET))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
